// File: rtl/bus_arbiter.sv
// Serializes IF and MEM requesters onto one memory bus, MEM first, with fetch
// cancellation and a bus-cycle timeout that completes the transaction with an error pulse.
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_cancel_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,

    output logic        stallreq_if_o,
    output logic        stallreq_mem_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        cancel_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [3:0]  bus_sel_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;
    logic        if_ack_q;
    logic        mem_ack_q;
    logic        bus_err_q;

    logic        timeout_d;
    logic        cancel_d;
    logic        finish_d;
    logic [31:0] rdata_d;

    assign timeout_d = (cnt_q == TIMEOUT_CNT);
    // A cancel arriving in the very cycle the slave acks still kills the fetch.
    assign cancel_d  = cancel_q | if_cancel_i;
    assign finish_d  = bus_ack_i | timeout_d;
    assign rdata_d   = bus_ack_i ? bus_rdata_i : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'h0;
            cancel_q    <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'h0;
                    if (mem_req_i) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_we_i;
                        bus_sel_q   <= mem_sel_i;
                        bus_addr_q  <= mem_addr_i;
                        bus_wdata_q <= mem_wdata_i;
                        state_q     <= MEM_BUSY;
                    end else if (if_req_i) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_sel_q   <= 4'hF;
                        bus_addr_q  <= if_addr_i;
                        state_q     <= IF_BUSY;
                    end
                end
                IF_BUSY: begin
                    if (if_cancel_i) begin
                        cancel_q <= 1'b1;
                    end
                    if (finish_d) begin
                        bus_req_q <= 1'b0;
                        bus_err_q <= ~bus_ack_i;
                        state_q   <= DONE;
                        if (!cancel_d) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= rdata_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'h1;
                    end
                end
                MEM_BUSY: begin
                    if (finish_d) begin
                        bus_req_q <= 1'b0;
                        bus_err_q <= ~bus_ack_i;
                        mem_ack_q <= 1'b1;
                        state_q   <= DONE;
                        if (!bus_we_q) begin
                            mem_rdata_q <= rdata_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'h1;
                    end
                end
                DONE: begin
                    cancel_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o     = if_rdata_q;
    assign if_ack_o       = if_ack_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign mem_ack_o      = mem_ack_q;
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_sel_o      = bus_sel_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign bus_err_o      = bus_err_q;

    assign stallreq_if_o  = if_req_i & ~if_ack_q;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand-written corner sequences and
// random transactions checked against a latency/data model of the arbiter.
module tb_bus_arbiter;

    localparam int TO = 4;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic        if_cancel_i = 1'b0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = 4'h0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = 32'h0;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_o;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_cancel_i(if_cancel_i),
        .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          dly;
        logic [31:0] data;
    } slv_t;

    typedef struct {
        bit          do_if;
        logic [31:0] if_addr;
        int          if_dly;
        logic [31:0] if_sd;
        bit          do_mem;
        bit          m_we;
        logic [3:0]  m_sel;
        logic [31:0] m_addr;
        logic [31:0] m_wd;
        int          m_dly;
        logic [31:0] m_sd;
        bit          stray;
        int          e_if_lat;
        logic [31:0] e_if_rd;
        bit          e_if_err;
        int          e_mem_lat;
        logic [31:0] e_mem_rd;
        bit          e_mem_err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    slv_t        slv_q[$];
    bit          force_ack = 1'b0;
    logic [31:0] mdl_if_rd = 32'h0;
    logic [31:0] mdl_mem_rd = 32'h0;

    // Bus slave: acks the k-th cycle (k = dly) of each bus_req_o period; drives at negedge.
    initial begin : slave
        int          req_cnt;
        int          cur_dly;
        logic [31:0] cur_data;
        slv_t        s;
        req_cnt = 0;
        cur_dly = NEVER;
        cur_data = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_req_o) begin
                if (req_cnt == 0) begin
                    if (slv_q.size() > 0) begin
                        s = slv_q.pop_front();
                        cur_dly = s.dly;
                        cur_data = s.data;
                    end else begin
                        cur_dly = NEVER;
                    end
                end
                bus_ack_i = (req_cnt == cur_dly);
                bus_rdata_i = (req_cnt == cur_dly) ? cur_data : $urandom;
                req_cnt++;
            end else begin
                req_cnt = 0;
                bus_ack_i = force_ack;
                bus_rdata_i = $urandom;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: each transaction acks 2+min(dly,TO) cycles after its request is sampled;
    // a second (IF) transaction is sampled in the IDLE cycle after the first DONE.
    function automatic vec_t predict(input vec_t v);
        int ki, km, start;
        vec_t r;
        r = v;
        ki = (v.if_dly > TO) ? TO : v.if_dly;
        km = (v.m_dly > TO) ? TO : v.m_dly;
        r.e_mem_lat = -1;
        r.e_mem_err = 1'b0;
        r.e_mem_rd = mdl_mem_rd;
        if (v.do_mem) begin
            r.e_mem_lat = 2 + km;
            r.e_mem_err = (v.m_dly > TO);
            if (!v.m_we) r.e_mem_rd = (v.m_dly > TO) ? 32'h0 : v.m_sd;
        end
        r.e_if_lat = -1;
        r.e_if_err = 1'b0;
        r.e_if_rd = mdl_if_rd;
        if (v.do_if) begin
            start = v.do_mem ? r.e_mem_lat + 1 : 0;
            r.e_if_lat = start + 2 + ki;
            r.e_if_err = (v.if_dly > TO);
            r.e_if_rd = (v.if_dly > TO) ? 32'h0 : v.if_sd;
        end
        return r;
    endfunction

    task automatic run(input vec_t v);
        int lim, rises;
        bit prev, own_mem;
        if (v.do_mem) slv_q.push_back(slv_t'{v.m_dly, v.m_sd});
        if (v.do_if) slv_q.push_back(slv_t'{v.if_dly, v.if_sd});
        if_req_i = v.do_if;
        if_addr_i = v.if_addr;
        mem_req_i = v.do_mem;
        mem_we_i = v.m_we;
        mem_sel_i = v.m_sel;
        mem_addr_i = v.m_addr;
        mem_wdata_i = v.m_wd;
        lim = ((v.e_if_lat > v.e_mem_lat) ? v.e_if_lat : v.e_mem_lat) + 2;
        prev = 1'b0;
        own_mem = 1'b0;
        rises = 0;
        for (int n = 1; n <= lim; n++) begin
            tick();
            if (bus_req_o && !prev) begin
                rises++;
                own_mem = v.do_mem && (rises == 1);
            end
            prev = bus_req_o;
            if (bus_req_o) begin
                chk("bus_we", bus_we_o, own_mem ? v.m_we : 1'b0);
                chk("bus_sel", bus_sel_o, own_mem ? v.m_sel : 4'hF);
                chk("bus_addr", bus_addr_o, own_mem ? v.m_addr : v.if_addr);
                if (own_mem && v.m_we) chk("bus_wdata", bus_wdata_o, v.m_wd);
            end
            chk("if_ack", if_ack_o, v.do_if && n == v.e_if_lat);
            chk("mem_ack", mem_ack_o, v.do_mem && n == v.e_mem_lat);
            chk("bus_err", bus_err_o, (v.do_if && v.e_if_err && n == v.e_if_lat) ||
                                      (v.do_mem && v.e_mem_err && n == v.e_mem_lat));
            chk("stall_if", stallreq_if_o, v.do_if && n < v.e_if_lat);
            chk("stall_mem", stallreq_mem_o, v.do_mem && n < v.e_mem_lat);
            if (v.do_if && n == v.e_if_lat) begin
                chk("if_rdata", if_rdata_o, v.e_if_rd);
                if_req_i = 1'b0;
            end
            if (v.do_mem && n == v.e_mem_lat) begin
                chk("mem_rdata", mem_rdata_o, v.e_mem_rd);
                mem_req_i = 1'b0;
            end
            force_ack = v.stray && v.do_mem && n == v.e_mem_lat;
        end
        chk("bus_rises", rises, 32'(int'(v.do_if) + int'(v.do_mem)));
        mdl_if_rd = v.e_if_rd;
        mdl_mem_rd = v.e_mem_rd;
        chk("if_rdata_hold", if_rdata_o, mdl_if_rd);
        chk("mem_rdata_hold", mem_rdata_o, mdl_mem_rd);
    endtask

    vec_t tbl[7];

    initial begin : main
        vec_t v;
        //           if: req addr      dly    sdata          mem: req we    sel   addr      wdata          dly    sdata         stray  e_if: lat rd  err       e_mem: lat rd err
        tbl[0] = '{1'b1, 32'h10, 2,     32'h3401_1100, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,         0,     32'h0,         1'b0, 4,  32'h3401_1100, 1'b0, -1, 32'h0,         1'b0};
        tbl[1] = '{1'b0, 32'h0,  0,     32'h0,         1'b1, 1'b0, 4'hF, 32'h40, 32'h0,         0,     32'hCAFE_F00D, 1'b0, -1, 32'h3401_1100, 1'b0, 2,  32'hCAFE_F00D, 1'b0};
        tbl[2] = '{1'b1, 32'h20, 0,     32'h1357_9BDF, 1'b1, 1'b1, 4'h3, 32'h80, 32'hDEAD_BEEF, 0,     32'hFFFF_0000, 1'b0, 5,  32'h1357_9BDF, 1'b0, 2,  32'hCAFE_F00D, 1'b0};
        tbl[3] = '{1'b0, 32'h0,  0,     32'h0,         1'b1, 1'b0, 4'hF, 32'h44, 32'h0,         NEVER, 32'h9999_9999, 1'b1, -1, 32'h1357_9BDF, 1'b0, 6,  32'h0,         1'b1};
        tbl[4] = '{1'b1, 32'h30, 4,     32'hA5A5_A5A5, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,         0,     32'h0,         1'b0, 6,  32'hA5A5_A5A5, 1'b0, -1, 32'h0,         1'b0};
        tbl[5] = '{1'b1, 32'h34, NEVER, 32'h7777_7777, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,         0,     32'h0,         1'b0, 6,  32'h0,         1'b1, -1, 32'h0,         1'b0};
        tbl[6] = '{1'b0, 32'h0,  0,     32'h0,         1'b1, 1'b0, 4'hC, 32'h48, 32'h0,         3,     32'h1111_2222, 1'b0, -1, 32'h0,         1'b0, 5,  32'h1111_2222, 1'b0};

        // Reset state, with stall following its equation while reset is held.
        if_req_i = 1'b1;
        #23;
        chk("rst_bus_req", bus_req_o, 1'b0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        chk("rst_bus_sel", bus_sel_o, 4'h0);
        chk("rst_acks", {if_ack_o, mem_ack_o, bus_err_o}, 3'b000);
        chk("rst_rdata", if_rdata_o | mem_rdata_o, 32'h0);
        chk("rst_stall_if", stallreq_if_o, 1'b1);
        if_req_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run(tbl[i]);

        // Cancelled fetch: bus cycle completes, no if_ack, if_rdata untouched.
        slv_q.push_back(slv_t'{2, 32'h1234_5678});
        if_req_i = 1'b1;
        if_addr_i = 32'h100;
        tick();
        chk("cancel_busreq", bus_req_o, 1'b1);
        if_cancel_i = 1'b1;
        if_req_i = 1'b0;
        for (int n = 2; n <= 6; n++) begin
            tick();
            if_cancel_i = 1'b0;
            chk("cancel_no_ack", if_ack_o, 1'b0);
            chk("cancel_no_err", bus_err_o, 1'b0);
            if (n == 3) chk("cancel_bus_runs", bus_req_o, 1'b1);
            if (n >= 4) chk("cancel_bus_done", bus_req_o, 1'b0);
        end
        chk("cancel_rdata", if_rdata_o, mdl_if_rd);
        v = tbl[0];
        v.if_addr = 32'h104;
        v.if_dly = 1;
        v.if_sd = 32'h0BAD_F00D;
        run(predict(v));

        // Stray ack in IDLE.
        force_ack = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            force_ack = 1'b0;
            chk("stray_acks", {if_ack_o, mem_ack_o, bus_err_o, bus_req_o}, 4'h0);
        end
        chk("stray_rdata", {if_rdata_o, mem_rdata_o}, {mdl_if_rd, mdl_mem_rd});

        // Reset in MEM_BUSY: bus_req_o drops before the next edge; held request restarts.
        slv_q.push_back(slv_t'{NEVER, 32'h0});
        mem_req_i = 1'b1;
        mem_we_i = 1'b0;
        mem_sel_i = 4'hF;
        mem_addr_i = 32'h200;
        tick();
        chk("rmid_busy", bus_req_o, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        chk("rmid_req_drop", bus_req_o, 1'b0);
        chk("rmid_bus_regs", {bus_we_o, bus_sel_o, bus_addr_o}, 37'h0);
        chk("rmid_rdata", if_rdata_o | mem_rdata_o, 32'h0);
        chk("rmid_stall_mem", stallreq_mem_o, 1'b1);
        mdl_if_rd = 32'h0;
        mdl_mem_rd = 32'h0;
        tick();
        chk("rmid_hold", {bus_req_o, mem_ack_o, bus_err_o}, 3'b000);
        slv_q.delete();
        slv_q.push_back(slv_t'{1, 32'h5555_AAAA});
        rst = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk("rmid_restart_req", bus_req_o, n == 1 || n == 2);
            chk("rmid_restart_ack", mem_ack_o, n == 3);
            if (n == 3) begin
                chk("rmid_restart_data", mem_rdata_o, 32'h5555_AAAA);
                mem_req_i = 1'b0;
                mdl_mem_rd = 32'h5555_AAAA;
            end
        end

        // Random traffic against the model.
        for (int i = 0; i < 30; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            v = tbl[0];
            v.do_if = (kind != 1);
            v.do_mem = (kind != 0);
            v.if_addr = $urandom;
            v.if_dly = $urandom_range(0, 6);
            v.if_sd = $urandom;
            v.m_we = $urandom_range(0, 1);
            v.m_sel = 4'($urandom_range(1, 15));
            v.m_addr = $urandom;
            v.m_wd = $urandom;
            v.m_dly = $urandom_range(0, 6);
            v.m_sd = $urandom;
            v.stray = $urandom_range(0, 1);
            run(predict(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
